// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU, the debug/DMA master and the memory decode.
// The arbiter takes the slave view. The environment (CPU, debug master and
// memory) takes the master view.
interface mem_bus_arbiter_if;
    logic [15:0] cpu_adr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;

    logic        dbg_req;
    logic [15:0] dbg_adr;
    logic        dbg_rw;
    logic [7:0]  dbg_dout;
    logic        dbg_gnt;
    logic        dbg_ack;
    logic [7:0]  dbg_din;

    logic [15:0] mem_adr;
    logic        mem_rw;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    modport slave (
        input  cpu_adr, cpu_rw, cpu_dout,
        input  dbg_req, dbg_adr, dbg_rw, dbg_dout,
        input  mem_din,
        output cpu_din, cpu_rdy,
        output dbg_gnt, dbg_ack, dbg_din,
        output mem_adr, mem_rw, mem_dout
    );

    modport master (
        output cpu_adr, cpu_rw, cpu_dout,
        output dbg_req, dbg_adr, dbg_rw, dbg_dout,
        output mem_din,
        input  cpu_din, cpu_rdy,
        input  dbg_gnt, dbg_ack, dbg_din,
        input  mem_adr, mem_rw, mem_dout
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the system memory bus between the CPU and a debug/DMA master.
// Debug bursts are bounded. After each handback the CPU is guaranteed a
// minimum window before the debug master can be granted again.
module mem_bus_arbiter #(
    parameter int DBG_BURST_MAX = 4,
    parameter int CPU_MIN       = 2
) (
    input logic              clk,
    input logic              n_reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int BURST_W = $clog2(DBG_BURST_MAX + 1);
    localparam int HOLD_W  = (CPU_MIN > 1) ? $clog2(CPU_MIN) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DBG_BURST_MAX - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(CPU_MIN - 1);

    typedef enum logic [1:0] {
        S_CPU,
        S_TURN_D,
        S_DBG,
        S_TURN_C
    } state_t;

    state_t              state, state_nxt;
    logic [BURST_W-1:0]  burst_cnt, burst_nxt;
    // Counts down the CPU cycles still owed before a re-grant.
    // When it is 0 the debug master may pre-empt the CPU in the current cycle.
    // Out of reset it is 0, so the debug master can take the bus at once.
    // After a handback the CPU keeps the bus for exactly CPU_MIN cycles.
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                accept;
    logic                acc_d1;
    logic                rd_d1;
    logic                ack_q;
    logic [7:0]          din_q;

    // Next-state, counter updates and bus steering for the current owner.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt    = state;
        burst_nxt    = burst_cnt;
        hold_nxt     = hold_cnt;
        accept       = 1'b0;
        bus.cpu_rdy  = 1'b0;
        bus.dbg_gnt  = 1'b0;
        bus.mem_adr  = bus.cpu_adr;
        bus.mem_rw   = 1'b1;
        bus.mem_dout = bus.cpu_dout;

        case (state)
            S_CPU: begin
                bus.cpu_rdy = 1'b1;
                bus.mem_rw  = bus.cpu_rw;
                if (bus.dbg_req && hold_cnt == '0) begin
                    state_nxt = S_TURN_D;
                end else if (hold_cnt != '0) begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_TURN_D: begin
                burst_nxt = '0;
                state_nxt = S_DBG;
            end
            S_DBG: begin
                bus.dbg_gnt  = 1'b1;
                bus.mem_adr  = bus.dbg_adr;
                bus.mem_dout = bus.dbg_dout;
                if (bus.dbg_req) begin
                    accept     = 1'b1;
                    bus.mem_rw = bus.dbg_rw;
                    burst_nxt  = burst_cnt + BURST_W'(1);
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = S_TURN_C;
                    end
                end else begin
                    state_nxt = S_TURN_C;
                end
            end
            S_TURN_C: begin
                hold_nxt  = HOLD_LOAD;
                state_nxt = S_CPU;
            end
            default: state_nxt = S_CPU;
        endcase
    end

    // Arbitration state and counters.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments, so every flop samples
        // values from before the edge, whatever the order of the statements.
        if (!n_reset) begin
            state     <= S_CPU;
            burst_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    // Ack pipeline. An access accepted in cycle k has its memory data in k+1
    // and is acknowledged in k+2.
    // This pipeline keeps running after the handback back to the CPU.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            acc_d1 <= 1'b0;
            rd_d1  <= 1'b0;
            ack_q  <= 1'b0;
            din_q  <= 8'h00;
        end else begin
            acc_d1 <= accept;
            rd_d1  <= accept & bus.dbg_rw;
            ack_q  <= acc_d1;
            if (rd_d1) begin
                din_q <= bus.mem_din;
            end
        end
    end

    assign bus.cpu_din = bus.mem_din;
    assign bus.dbg_ack = ack_q;
    assign bus.dbg_din = din_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// The reference model tracks who owns the bus, the expected ack times and a
// shadow copy of memory. The checks run every cycle inside tick(). The
// scenario tasks add their own checks on top.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int DBG_BURST_MAX = 4;
    localparam int CPU_MIN       = 2;

    localparam int OWN_CPU = 0;
    localparam int OWN_IN  = 1;
    localparam int OWN_DBG = 2;
    localparam int OWN_OUT = 3;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .DBG_BURST_MAX(DBG_BURST_MAX),
        .CPU_MIN      (CPU_MIN)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    function automatic logic [7:0] img(input logic [15:0] a);
        if (a == 16'h1234) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory: samples adr/rw/dout at posedge, read data valid the next cycle.
    logic [7:0] ram [0:65535];
    logic [7:0] mem_din_r;
    bit         ram_loaded;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 65536; i++) ram[i] <= img(16'(i));
            ram_loaded <= 1'b1;
        end else if (bus.mem_rw) begin
            mem_din_r <= ram[bus.mem_adr];
        end else begin
            ram[bus.mem_adr] <= bus.mem_dout;
        end
    end
    assign bus.mem_din = mem_din_r;

    typedef struct {
        int         due;
        bit         rd;
        logic [7:0] data;
    } ack_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         m_valid = 1'b0;
    int         m_own;
    int         m_owed;
    int         m_burst;
    int         m_accepts = 0;
    logic [7:0] m_din;
    logic [7:0] shadow [0:65535];
    ack_t       ack_q [$];
    int         obs_rdy_low, obs_ack, obs_wr;

    task automatic reset_model();
        m_own   = OWN_CPU;
        m_owed  = 0;
        m_burst = 0;
        m_din   = 8'h00;
        ack_q.delete();
        m_valid = 1'b1;
    endtask

    // One bus cycle. Compares the outputs against the model, advances the
    // model, then moves on to the next negedge.
    task automatic tick();
        logic        exp_rdy, exp_gnt, acc, exp_rw, exp_ack;
        logic [15:0] exp_adr;
        logic [7:0]  exp_dout;
        ack_t        ent;
        #1;
        if (m_valid) begin
            exp_rdy  = (m_own == OWN_CPU);
            exp_gnt  = (m_own == OWN_DBG);
            acc      = exp_gnt && bus.dbg_req;
            exp_adr  = exp_gnt ? bus.dbg_adr : bus.cpu_adr;
            exp_dout = exp_gnt ? bus.dbg_dout : bus.cpu_dout;
            exp_rw   = exp_rdy ? bus.cpu_rw : (acc ? bus.dbg_rw : 1'b1);
            exp_ack  = (ack_q.size() != 0) && (ack_q[0].due == cyc);
            if (exp_ack) begin
                ent = ack_q.pop_front();
                if (ent.rd) m_din = ent.data;
            end
            n_checks++;
            if (bus.cpu_rdy !== exp_rdy) begin
                n_errors++; $display("FAIL cpu_rdy cyc=%0d got=%b exp=%b", cyc, bus.cpu_rdy, exp_rdy);
            end
            n_checks++;
            if (bus.dbg_gnt !== exp_gnt) begin
                n_errors++; $display("FAIL dbg_gnt cyc=%0d got=%b exp=%b", cyc, bus.dbg_gnt, exp_gnt);
            end
            n_checks++;
            if (bus.mem_adr !== exp_adr) begin
                n_errors++; $display("FAIL mem_adr cyc=%0d got=%h exp=%h", cyc, bus.mem_adr, exp_adr);
            end
            n_checks++;
            if (bus.mem_rw !== exp_rw) begin
                n_errors++; $display("FAIL mem_rw cyc=%0d got=%b exp=%b", cyc, bus.mem_rw, exp_rw);
            end
            if (!exp_rw) begin
                n_checks++;
                if (bus.mem_dout !== exp_dout) begin
                    n_errors++; $display("FAIL mem_dout cyc=%0d got=%h exp=%h", cyc, bus.mem_dout, exp_dout);
                end
            end
            n_checks++;
            if (bus.cpu_din !== bus.mem_din) begin
                n_errors++; $display("FAIL cpu_din cyc=%0d got=%h exp=%h", cyc, bus.cpu_din, bus.mem_din);
            end
            n_checks++;
            if (bus.dbg_ack !== exp_ack) begin
                n_errors++; $display("FAIL dbg_ack cyc=%0d got=%b exp=%b", cyc, bus.dbg_ack, exp_ack);
            end
            n_checks++;
            if (bus.dbg_din !== m_din) begin
                n_errors++; $display("FAIL dbg_din cyc=%0d got=%h exp=%h", cyc, bus.dbg_din, m_din);
            end

            if (acc) begin
                ack_q.push_back('{cyc + 2, bus.dbg_rw, shadow[bus.dbg_adr]});
                m_accepts++;
            end
            if (!exp_rw) shadow[exp_adr] = exp_dout;

            if (!n_reset) begin
                reset_model();
            end else begin
                case (m_own)
                    OWN_CPU: begin
                        if (bus.dbg_req && m_owed == 0) m_own = OWN_IN;
                        else if (m_owed > 0) m_owed--;
                    end
                    OWN_IN: begin
                        m_burst = 0;
                        m_own   = OWN_DBG;
                    end
                    OWN_DBG: begin
                        if (acc) begin
                            m_burst++;
                            if (m_burst == DBG_BURST_MAX) m_own = OWN_OUT;
                        end else begin
                            m_own = OWN_OUT;
                        end
                    end
                    default: begin
                        m_owed = CPU_MIN - 1;
                        m_own  = OWN_CPU;
                    end
                endcase
            end
        end else if (!n_reset) begin
            reset_model();
        end
        if (bus.cpu_rdy === 1'b0) obs_rdy_low++;
        if (bus.dbg_ack === 1'b1) obs_ack++;
        if (bus.mem_rw === 1'b0) obs_wr++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_idle();
        bus.cpu_adr  = 16'h8000;
        bus.cpu_rw   = 1'b1;
        bus.cpu_dout = 8'h00;
        bus.dbg_req  = 1'b0;
        bus.dbg_adr  = 16'h0000;
        bus.dbg_rw   = 1'b1;
        bus.dbg_dout = 8'h00;
    endtask

    // A single debug access. The requester drops dbg_req after it is accepted.
    task automatic run_single(input logic rw, input logic [15:0] adr, input logic [7:0] dout,
                              output int acc_cyc, output int ack_cyc, output logic [7:0] ack_din);
        run_idle(CPU_MIN + 2);
        obs_rdy_low = 0; obs_ack = 0; obs_wr = 0;
        bus.dbg_adr = adr; bus.dbg_rw = rw; bus.dbg_dout = dout; bus.dbg_req = 1'b1;
        acc_cyc = -1; ack_cyc = -1; ack_din = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (bus.dbg_ack === 1'b1 && ack_cyc < 0) begin
                ack_cyc = cyc;
                ack_din = bus.dbg_din;
            end
            if (bus.dbg_req && bus.dbg_gnt === 1'b1) acc_cyc = cyc;
            tick();
            if (acc_cyc >= 0) bus.dbg_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; bus.dbg_req = 1'b1; bus.cpu_adr = 16'h8000;
        tick();
        n_checks++;
        if (bus.cpu_rdy !== 1'b1 || bus.dbg_gnt !== 1'b0 || bus.dbg_ack !== 1'b0 || bus.mem_adr !== 16'h8000) begin
            n_errors++;
            $display("FAIL reset_outputs got rdy=%b gnt=%b ack=%b adr=%h exp 1 0 0 8000",
                     bus.cpu_rdy, bus.dbg_gnt, bus.dbg_ack, bus.mem_adr);
        end
        tick();
        n_reset = 1'b1;
        tick();
        n_checks++;
        if (bus.cpu_rdy !== 1'b0) begin
            n_errors++; $display("FAIL reset_preempt got cpu_rdy=%b exp=0", bus.cpu_rdy);
        end
        tick();
        n_checks++;
        if (bus.dbg_gnt !== 1'b1) begin
            n_errors++; $display("FAIL reset_first_grant got dbg_gnt=%b exp=1", bus.dbg_gnt);
        end
        bus.dbg_req = 1'b0;
        run_idle(6);
    endtask

    task automatic test_single_write();
        int acc_cyc, ack_cyc;
        logic [7:0] ack_din;
        run_single(1'b0, 16'h0200, 8'hA5, acc_cyc, ack_cyc, ack_din);
        n_checks++;
        if (ack_cyc - acc_cyc != 2 || acc_cyc < 0) begin
            n_errors++; $display("FAIL write_ack_latency got=%0d exp=2", ack_cyc - acc_cyc);
        end
        n_checks++;
        if (obs_ack != 1 || obs_wr != 1) begin
            n_errors++; $display("FAIL write_counts got acks=%0d writes=%0d exp 1 1", obs_ack, obs_wr);
        end
        // The stall is TURN_D, the accepted access, the S_DBG cycle where the
        // request is already low (one access does not end the burst), then TURN_C.
        n_checks++;
        if (obs_rdy_low != 4) begin
            n_errors++; $display("FAIL write_stall got=%0d exp=4", obs_rdy_low);
        end
        n_checks++;
        if (ram[16'h0200] !== 8'hA5) begin
            n_errors++; $display("FAIL write_mem got=%h exp=a5", ram[16'h0200]);
        end
    endtask

    task automatic test_single_read();
        int acc_cyc, ack_cyc;
        logic [7:0] ack_din;
        run_single(1'b1, 16'h1234, 8'h00, acc_cyc, ack_cyc, ack_din);
        n_checks++;
        if (ack_cyc - acc_cyc != 2 || acc_cyc < 0) begin
            n_errors++; $display("FAIL read_ack_latency got=%0d exp=2", ack_cyc - acc_cyc);
        end
        n_checks++;
        if (ack_din !== 8'h3C) begin
            n_errors++; $display("FAIL read_data got=%h exp=3c", ack_din);
        end
        n_checks++;
        if (obs_ack != 1 || obs_wr != 0) begin
            n_errors++; $display("FAIL read_counts got acks=%0d writes=%0d exp 1 0", obs_ack, obs_wr);
        end
    endtask

    task automatic test_burst();
        int blen, rlen, nbursts, acc0;
        bit prev_g, prev_r, g, r;
        run_idle(CPU_MIN + 2);
        obs_ack = 0; acc0 = m_accepts;
        blen = 0; rlen = 0; nbursts = 0; prev_g = 1'b0; prev_r = 1'b1;
        bus.dbg_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            g = (bus.dbg_gnt === 1'b1);
            r = (bus.cpu_rdy === 1'b1);
            if (g) blen++;
            else if (prev_g) begin
                n_checks++;
                if (blen != DBG_BURST_MAX) begin
                    n_errors++; $display("FAIL burst_len got=%0d exp=%0d", blen, DBG_BURST_MAX);
                end
                blen = 0; nbursts++;
            end
            if (r) rlen++;
            else if (prev_r) begin
                if (nbursts > 0) begin
                    n_checks++;
                    if (rlen != CPU_MIN) begin
                        n_errors++; $display("FAIL cpu_window got=%0d exp=%0d", rlen, CPU_MIN);
                    end
                end
                rlen = 0;
            end
            prev_g = g; prev_r = r;
            bus.dbg_adr  = {8'h03, 8'($urandom_range(0, 15))};
            bus.dbg_rw   = 1'($urandom);
            bus.dbg_dout = 8'($urandom);
            tick();
        end
        bus.dbg_req = 1'b0;
        run_idle(8);
        n_checks++;
        if (nbursts < 3) begin
            n_errors++; $display("FAIL burst_count got=%0d exp>=3", nbursts);
        end
        n_checks++;
        if (obs_ack != m_accepts - acc0) begin
            n_errors++; $display("FAIL burst_acks got=%0d exp=%0d", obs_ack, m_accepts - acc0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int waited;
        run_idle(CPU_MIN + 2);
        bus.dbg_req = 1'b1; bus.dbg_rw = 1'b1; bus.dbg_adr = 16'h1234;
        waited = 0;
        while (bus.dbg_gnt !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited >= 10) begin
            n_errors++; $display("FAIL mid_reset_grant_timeout got waited=%0d exp<10", waited);
        end
        tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1; bus.dbg_req = 1'b0;
        n_checks++;
        if (bus.cpu_rdy !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_state got rdy=%b gnt=%b exp 1 0", bus.cpu_rdy, bus.dbg_gnt);
        end
        obs_ack = 0;
        run_idle(6);
        n_checks++;
        if (obs_ack != 0) begin
            n_errors++; $display("FAIL mid_reset_acks got=%0d exp=0", obs_ack);
        end
    endtask

    task automatic test_drop_in_turn();
        run_idle(CPU_MIN + 2);
        obs_rdy_low = 0; obs_ack = 0; obs_wr = 0;
        bus.dbg_req = 1'b1; bus.dbg_rw = 1'b0; bus.dbg_adr = 16'h0300; bus.dbg_dout = 8'hFF;
        tick();
        bus.dbg_req = 1'b0;
        run_idle(8);
        n_checks++;
        if (obs_rdy_low != 3) begin
            n_errors++; $display("FAIL drop_stall got=%0d exp=3", obs_rdy_low);
        end
        n_checks++;
        if (obs_wr != 0 || obs_ack != 0) begin
            n_errors++; $display("FAIL drop_activity got writes=%0d acks=%0d exp 0 0", obs_wr, obs_ack);
        end
        n_checks++;
        if (ram[16'h0300] !== img(16'h0300)) begin
            n_errors++; $display("FAIL drop_mem got=%h exp=%h", ram[16'h0300], img(16'h0300));
        end
    endtask

    task automatic test_random();
        int acc0;
        obs_ack = 0; acc0 = m_accepts;
        for (int i = 0; i < 400; i++) begin
            bus.dbg_req  = ($urandom_range(0, 9) < 6);
            bus.dbg_rw   = 1'($urandom);
            bus.dbg_adr  = {8'h02, 8'($urandom_range(0, 15))};
            bus.dbg_dout = 8'($urandom);
            bus.cpu_rw   = ($urandom_range(0, 3) != 0);
            bus.cpu_adr  = ($urandom_range(0, 1) != 0) ? {8'h02, 8'($urandom_range(0, 15))} : 16'($urandom);
            bus.cpu_dout = 8'($urandom);
            tick();
        end
        drive_idle();
        run_idle(8);
        n_checks++;
        if (obs_ack != m_accepts - acc0) begin
            n_errors++; $display("FAIL random_acks got=%0d exp=%0d", obs_ack, m_accepts - acc0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = img(16'(i));
        drive_idle();
        n_reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_single_read();
        test_burst();
        test_reset_mid_burst();
        test_drop_in_turn();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
